data_mem_responder: RTL

Responder end of the CPU data-memory port: accepts the chip-enable / write-enable / byte-select / address / data requests driven by the MEM stage and services them from an internal word-organised, byte-laned RAM with a fixed, parameterised access latency. During each access it raises a stall request to the pipeline control unit so the MEM stage holds its request stable. When the access completes, it returns the full read word for the MEM stage's byte/halfword extraction logic.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_bank.sv | 42 ++++
 rtl/data_mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, counter width
// and the pipeline-wide chip/write enable levels.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/data_mem_bank.sv
// Word-organised RAM with four byte-lane write enables, one port and a
// registered read word that only changes on a read access.
module data_mem_bank
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i && (we_i == WriteEnable)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (en_i && (we_i == WriteDisable)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: captures a MEM-stage request, stalls
// the pipeline for a fixed latency, then performs the access on the bank.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic        stallreq_o
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2-1:0] idx_q;

  logic accept;
  logic access;
  logic unused_addr;

  assign accept = (state_q == IDLE) && (ce_i == ChipEnable) && !flush_i;
  assign access = (state_q == BUSY) && !flush_i && (cnt_q == '0);

  // Request fields are frozen at acceptance; inputs seen during BUSY are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= WriteDisable;
      sel_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= we_i;
            sel_q   <= sel_i;
            wdata_q <= data_i;
            idx_q   <= addr_i[DEPTH_LOG2+1:2];
            cnt_q   <= CntLoad;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  data_mem_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .en_i   (access),
    .we_i   (we_q),
    .be_i   (sel_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(data_o)
  );

  assign stallreq_o = accept || (state_q == BUSY);

  // Byte offset and high address bits alias onto the same word.
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

endmodule
